cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_if.sv | 38 +++
 rtl/cacheline_adapter.sv | 123 ++++++++++++
 tb/tb_cacheline_adapter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adapter_if.sv
// Cache-line / burst-memory signal bundle for cacheline_adapter.
// master: the adapter itself; slave: the cache and memory it sits between.
interface cacheline_adapter_if #(
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned BURST_LEN = 4
);
  localparam int unsigned LINE_W = BEAT_W * BURST_LEN;

  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Converts whole-line cache fills/writebacks into BURST_LEN-beat memory bursts.
// Optional CACHELINE_ADAPTER_RADDR_CHECK_EN: only count read beats whose bmem_raddr matches the line.
module cacheline_adapter #(
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned BURST_LEN = 4
) (
  input logic               clk,
  input logic               rst,
  cacheline_adapter_if.master bus
);
  localparam int unsigned LINE_W = BEAT_W * BURST_LEN;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] line_q;
  logic              latch_addr;
  logic              latch_line;
  logic              beat_accept;
  logic              beat_ok;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  assign beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);
`else
  logic unused_raddr;
  assign unused_raddr = ^bus.bmem_raddr;
  assign beat_ok      = bus.bmem_rvalid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    latch_addr      = 1'b0;
    latch_line      = 1'b0;
    beat_accept     = 1'b0;
    bus.dfp_resp    = 1'b0;
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_addr   = '0;
    bus.bmem_wdata  = '0;

    unique case (state)
      IDLE: begin
        cnt_next = '0;
        // Writeback takes priority so a dirty victim is never overwritten by its fill.
        if (bus.dfp_write) begin
          latch_addr = 1'b1;
          latch_line = 1'b1;
          state_next = WR_BURST;
        end else if (bus.dfp_read) begin
          latch_addr = 1'b1;
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
        if (bus.bmem_ready) begin
          cnt_next   = '0;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (beat_ok) begin
          beat_accept = 1'b1;
          cnt_next    = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) state_next = RESP;
        end
      end
      WR_BURST: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = line_q[BEAT_W*cnt +: BEAT_W];
        if (bus.bmem_ready) begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) state_next = RESP;
        end
      end
      RESP: begin
        bus.dfp_resp = 1'b1;
        cnt_next     = '0;
        state_next   = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      line_q        <= '0;
      bus.dfp_rdata <= '0;
    end else begin
      if (latch_addr) addr_q <= {bus.dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
      if (latch_line) line_q <= bus.dfp_wdata;
      if (beat_accept) bus.dfp_rdata[BEAT_W*cnt +: BEAT_W] <= bus.bmem_rdata;
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter: reset, fill, stalled writeback,
// write priority with back-to-back fill, reset mid-burst, and read-address tag handling.
module tb_cacheline_adapter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cacheline_adapter_if #(.BEAT_W(64), .BURST_LEN(4)) bus ();

  cacheline_adapter #(.BEAT_W(64), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.dfp_addr    = '0;
    bus.dfp_read    = 1'b0;
    bus.dfp_write   = 1'b0;
    bus.dfp_wdata   = '0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_raddr  = '0;
    bus.bmem_rdata  = '0;
    bus.bmem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b expected 0", bus.dfp_resp); end
    checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", bus.bmem_read); end
    checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b expected 0", bus.bmem_write); end
    checks++; if (bus.bmem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.bmem_addr); end
    checks++; if (bus.bmem_wdata !== 64'h0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", bus.bmem_wdata); end
    checks++; if (bus.dfp_rdata !== 256'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.dfp_rdata); end
  endtask

  task automatic test_read;
    logic [63:0]  beats [4];
    logic [255:0] exp_line;
    beats    = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    next_cycle();
    // cycle 0
    bus.dfp_addr   = 32'h1234_5678;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL rd_idle_read: got %b expected 0", bus.bmem_read); end
    // cycle 1: request issued; a stray beat here must be ignored
    next_cycle();
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.bmem_raddr  = 32'h1234_5660;
    @(negedge clk);
    checks++; if (bus.bmem_read !== 1'b1) begin errors++; $display("FAIL rd_req_read: got %b expected 1", bus.bmem_read); end
    checks++; if (bus.bmem_addr !== 32'h1234_5660) begin errors++; $display("FAIL rd_req_addr: got %h expected 12345660", bus.bmem_addr); end
    // cycles 2-5: beats
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.bmem_rdata = beats[i];
      @(negedge clk);
      checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL rd_wait_read[%0d]: got %b expected 0", i, bus.bmem_read); end
      checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_wait_resp[%0d]: got %b expected 0", i, bus.dfp_resp); end
    end
    // cycle 6: response
    next_cycle();
    bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b1) begin errors++; $display("FAIL rd_resp: got %b expected 1", bus.dfp_resp); end
    checks++; if (bus.dfp_rdata !== exp_line) begin errors++; $display("FAIL rd_line: got %h expected %h", bus.dfp_rdata, exp_line); end
    checks++; if (bus.bmem_addr !== 32'h0) begin errors++; $display("FAIL rd_resp_addr: got %h expected 0", bus.bmem_addr); end
    // cycle 7: single-cycle pulse, line held
    next_cycle();
    bus.dfp_read = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse: got %b expected 0", bus.dfp_resp); end
    checks++; if (bus.dfp_rdata !== exp_line) begin errors++; $display("FAIL rd_line_hold: got %h expected %h", bus.dfp_rdata, exp_line); end
  endtask

  task automatic test_write_stall;
    logic [63:0]  b [4];
    logic [255:0] line;
    logic [255:0] prev_line;
    logic         rdy [6];
    int           idx [6];
    b         = '{64'hBBBB_BBBB_BBBB_0000, 64'hBBBB_BBBB_BBBB_1111,
                  64'hAAAA_AAAA_AAAA_2222, 64'hAAAA_AAAA_AAAA_3333};
    line      = {b[3], b[2], b[1], b[0]};
    prev_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rdy       = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    idx       = '{0, 1, 1, 2, 3, 3};
    next_cycle();
    bus.dfp_addr   = 32'h0000_105C;
    bus.dfp_wdata  = line;
    bus.dfp_write  = 1'b1;
    bus.bmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL wr_idle_write: got %b expected 0", bus.bmem_write); end
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      bus.bmem_ready = rdy[i];
      @(negedge clk);
      checks++; if (bus.bmem_write !== 1'b1) begin errors++; $display("FAIL wr_write[%0d]: got %b expected 1", i, bus.bmem_write); end
      checks++; if (bus.bmem_addr !== 32'h0000_1040) begin errors++; $display("FAIL wr_addr[%0d]: got %h expected 00001040", i, bus.bmem_addr); end
      checks++; if (bus.bmem_wdata !== b[idx[i]]) begin errors++; $display("FAIL wr_wdata[%0d]: got %h expected %h", i, bus.bmem_wdata, b[idx[i]]); end
      checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL wr_early_resp[%0d]: got %b expected 0", i, bus.dfp_resp); end
    end
    next_cycle();
    bus.bmem_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b1) begin errors++; $display("FAIL wr_resp: got %b expected 1", bus.dfp_resp); end
    checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL wr_resp_write: got %b expected 0", bus.bmem_write); end
    checks++; if (bus.bmem_wdata !== 64'h0) begin errors++; $display("FAIL wr_resp_wdata: got %h expected 0", bus.bmem_wdata); end
    checks++; if (bus.dfp_rdata !== prev_line) begin errors++; $display("FAIL wr_rdata_hold: got %h expected %h", bus.dfp_rdata, prev_line); end
    next_cycle();
    bus.dfp_write = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL wr_resp_pulse: got %b expected 0", bus.dfp_resp); end
  endtask

  task automatic test_back_to_back;
    logic [63:0]  w [4];
    logic [63:0]  r [4];
    logic [255:0] exp_line;
    w        = '{64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001,
                 64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0003};
    r        = '{64'h5A5A_0000_0000_00A0, 64'h5A5A_0000_0000_00A1,
                 64'h5A5A_0000_0000_00A2, 64'h5A5A_0000_0000_00A3};
    exp_line = {r[3], r[2], r[1], r[0]};
    next_cycle();
    // cycle 0: both requests raised together, writeback must win
    bus.dfp_addr   = 32'h0000_3000;
    bus.dfp_wdata  = {w[3], w[2], w[1], w[0]};
    bus.dfp_write  = 1'b1;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (bus.bmem_write !== 1'b1) begin errors++; $display("FAIL b2b_write[%0d]: got %b expected 1", i, bus.bmem_write); end
      checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL b2b_no_read[%0d]: got %b expected 0", i, bus.bmem_read); end
      checks++; if (bus.bmem_wdata !== w[i]) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", i, bus.bmem_wdata, w[i]); end
    end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b1) begin errors++; $display("FAIL b2b_wr_resp: got %b expected 1", bus.dfp_resp); end
    checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL b2b_resp_read: got %b expected 0", bus.bmem_read); end
    // cycle 6: writeback done, fill still pending on a new address
    next_cycle();
    bus.dfp_write = 1'b0;
    bus.dfp_addr  = 32'h0000_7000;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL b2b_idle_resp: got %b expected 0", bus.dfp_resp); end
    checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle_read: got %b expected 0", bus.bmem_read); end
    checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL b2b_idle_write: got %b expected 0", bus.bmem_write); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.bmem_read !== 1'b1) begin errors++; $display("FAIL b2b_rd_req: got %b expected 1", bus.bmem_read); end
    checks++; if (bus.bmem_addr !== 32'h0000_7000) begin errors++; $display("FAIL b2b_rd_addr: got %h expected 00007000", bus.bmem_addr); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = 32'h0000_7000;
      bus.bmem_rdata  = r[i];
      @(negedge clk);
      checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL b2b_rd_dup[%0d]: got %b expected 0", i, bus.bmem_read); end
    end
    next_cycle();
    bus.bmem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b1) begin errors++; $display("FAIL b2b_rd_resp: got %b expected 1", bus.dfp_resp); end
    checks++; if (bus.dfp_rdata !== exp_line) begin errors++; $display("FAIL b2b_rd_line: got %h expected %h", bus.dfp_rdata, exp_line); end
    next_cycle();
    bus.dfp_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL b2b_after_read[%0d]: got %b expected 0", i, bus.bmem_read); end
      checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL b2b_after_resp[%0d]: got %b expected 0", i, bus.dfp_resp); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_read;
    next_cycle();
    // cycle 0
    bus.dfp_addr   = 32'h0000_2000;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b0;
    // cycles 1-2: request stalls then is accepted
    next_cycle();
    @(negedge clk);
    checks++; if (bus.bmem_read !== 1'b1) begin errors++; $display("FAIL mid_req: got %b expected 1", bus.bmem_read); end
    next_cycle();
    bus.bmem_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.bmem_read !== 1'b1) begin errors++; $display("FAIL mid_req_stall: got %b expected 1", bus.bmem_read); end
    checks++; if (bus.bmem_addr !== 32'h0000_2000) begin errors++; $display("FAIL mid_req_addr: got %h expected 00002000", bus.bmem_addr); end
    // cycles 3-4: two beats, then reset
    next_cycle();
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b1;
    bus.bmem_raddr  = 32'h0000_2000;
    bus.bmem_rdata  = 64'h0101_0101_0101_0101;
    next_cycle();
    bus.bmem_rdata  = 64'h0202_0202_0202_0202;
    next_cycle();
    rst             = 1'b1;
    bus.bmem_rvalid = 1'b0;
    next_cycle();
    rst          = 1'b0;
    bus.dfp_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bmem_rvalid = (i < 3);
      bus.bmem_rdata  = 64'h0303_0303_0303_0303 + 64'(i);
      @(negedge clk);
      checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL mid_resp[%0d]: got %b expected 0", i, bus.dfp_resp); end
      checks++; if (bus.bmem_read !== 1'b0) begin errors++; $display("FAIL mid_read[%0d]: got %b expected 0", i, bus.bmem_read); end
      checks++; if (bus.bmem_write !== 1'b0) begin errors++; $display("FAIL mid_write[%0d]: got %b expected 0", i, bus.bmem_write); end
      checks++; if (bus.bmem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr[%0d]: got %h expected 0", i, bus.bmem_addr); end
      checks++; if (bus.dfp_rdata !== 256'h0) begin errors++; $display("FAIL mid_rdata[%0d]: got %h expected 0", i, bus.dfp_rdata); end
      next_cycle();
    end
  endtask

  task automatic test_raddr_tag;
    logic [63:0]  g [4];
    logic [63:0]  bad;
    logic [63:0]  data [5];
    logic [31:0]  tag [5];
    logic         exp_resp [5];
    logic [255:0] exp_line;
    g    = '{64'h7000_0000_0000_0010, 64'h7000_0000_0000_0011,
             64'h7000_0000_0000_0012, 64'h7000_0000_0000_0013};
    bad  = 64'hFFFF_FFFF_FFFF_FFFF;
    data = '{g[0], bad, g[1], g[2], g[3]};
    tag  = '{32'h0000_4020, 32'hDEAD_BEE0, 32'h0000_4020, 32'h0000_4020, 32'h0000_4020};
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    exp_resp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_line = {g[3], g[2], g[1], g[0]};
`else
    exp_resp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_line = {g[2], g[1], bad, g[0]};
`endif
    next_cycle();
    bus.dfp_addr   = 32'h0000_4020;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = data[i];
      bus.bmem_raddr  = tag[i];
      @(negedge clk);
      checks++; if (bus.dfp_resp !== exp_resp[i]) begin errors++; $display("FAIL tag_resp[%0d]: got %b expected %b", i, bus.dfp_resp, exp_resp[i]); end
    end
    next_cycle();
    bus.bmem_rvalid = 1'b0;
`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b1) begin errors++; $display("FAIL tag_final_resp: got %b expected 1", bus.dfp_resp); end
    next_cycle();
`endif
    bus.dfp_read = 1'b0;
    @(negedge clk);
    checks++; if (bus.dfp_resp !== 1'b0) begin errors++; $display("FAIL tag_resp_pulse: got %b expected 0", bus.dfp_resp); end
    checks++; if (bus.dfp_rdata !== exp_line) begin errors++; $display("FAIL tag_line: got %h expected %h", bus.dfp_rdata, exp_line); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_write_stall();
    test_back_to_back();
    test_reset_mid_read();
    test_raddr_tag();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
